regfile_read_arbiter: RTL

Sequencer and arbiter for the register file's single 32-to-1 read multiplexer in the multi-cycle CPU datapath. Up to N requesters (e.g. the two operand fetch paths, the debug port, the exception unit) each ask for a register by 5-bit index. The block grants them one at a time in round-robin order and drives the mux select. It captures the mux output into a holding register and returns the word with a one-cycle grant pulse.

---
 rtl/regfile_read_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin sequencer for the register file's single read mux: arbitrate, drive select, capture, grant.
// Latency: request seen in IDLE at t -> mux_select at t+1, grant pulse with rdata at t+3; one read per 3 cycles.
// Backpressure: none; requesters hold req level until their grant, others simply wait their turn.
module regfile_read_arbiter #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [5*N-1:0]   addr,
    output logic [4:0]       mux_select,
    input  logic [W-1:0]     mux_data,
    output logic [W-1:0]     rdata,
    output logic [N-1:0]     grant,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pick;
    logic            pick_vld;

    // Scan downward so the last hit wins: that is the first set bit at or above ptr, with wrap at N.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                pick_vld = 1'b1;
                pick     = PW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = DRIVE;
            DRIVE:   state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            owner      <= '0;
            mux_select <= '0;
            rdata      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            grant <= '0;
            busy  <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    // addr is captured only here; later addr/req changes cannot disturb the read
                    if (pick_vld) begin
                        owner      <= pick;
                        mux_select <= addr[5*int'(pick) +: 5];
                    end
                end
                LATCH: begin
                    rdata <= mux_data;
                    grant <= {{(N-1){1'b0}}, 1'b1} << owner;
                    ptr   <= (int'(owner) == N - 1) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
